// File: rtl/axi_remap_pkg.sv
// rtl/axi_remap_pkg.sv - shared constants, AR/AW sideband layout and region lookup helper
package axi_remap_pkg;

  localparam int REGION_BITS_DEF = 4;
  localparam int MAX_REGIONS     = 8;
  localparam int MAX_RB          = 16;

  // Sideband layout, LSB upward: qos, prot, cache, lock, burst, size, len, id
  localparam int META_QOS_W    = 4;
  localparam int META_QOS_OFF  = 0;
  localparam int META_PROT_W   = 3;
  localparam int META_PROT_OFF = META_QOS_OFF + META_QOS_W;
  localparam int META_CACHE_W  = 4;
  localparam int META_CACHE_OFF = META_PROT_OFF + META_PROT_W;
  localparam int META_LOCK_W   = 1;
  localparam int META_LOCK_OFF = META_CACHE_OFF + META_CACHE_W;
  localparam int META_BURST_W  = 2;
  localparam int META_BURST_OFF = META_LOCK_OFF + META_LOCK_W;
  localparam int META_SIZE_W   = 3;
  localparam int META_SIZE_OFF = META_BURST_OFF + META_BURST_W;
  localparam int META_LEN_W    = 8;
  localparam int META_LEN_OFF  = META_SIZE_OFF + META_SIZE_W;
  localparam int META_ID_W     = 6;
  localparam int META_ID_OFF   = META_LEN_OFF + META_LEN_W;
  localparam int META_W_DEF    = META_ID_OFF + META_ID_W;

  typedef struct packed {
    logic              hit;
    logic [MAX_RB-1:0] hi;
  } remap_res_t;

  // Walk from the top index down so the lowest matching entry is the last writer.
  function automatic remap_res_t remap_hi(
    input logic [MAX_RB-1:0]             hi,
    input logic [MAX_REGIONS*MAX_RB-1:0] match_tab,
    input logic [MAX_REGIONS*MAX_RB-1:0] remap_tab,
    input logic [MAX_REGIONS-1:0]        en,
    input logic [MAX_RB-1:0]             dflt
  );
    remap_res_t res;
    res.hit = 1'b0;
    res.hi  = dflt;
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (en[i] && (match_tab[i*MAX_RB +: MAX_RB] == hi)) begin
        res.hit = 1'b1;
        res.hi  = remap_tab[i*MAX_RB +: MAX_RB];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_skid_slice.sv
// rtl/axi_skid_slice.sv - two-entry full-throughput register slice (main + skid)
module axi_skid_slice #(
  parameter int WIDTH = 63
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [WIDTH-1:0] i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_data
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_s_hs;

  // Ready is held low through reset so nothing is accepted while state clears.
  assign o_s_ready = !r_skid_valid && !i_reset;
  assign w_s_hs    = i_s_valid && o_s_ready;
  assign o_m_valid = r_main_valid;
  assign o_m_data  = r_main_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (i_m_ready) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (!r_main_valid || i_m_ready) begin
      r_main_valid <= w_s_hs;
      if (w_s_hs) begin
        r_main_data <= i_s_data;
      end
    end else if (w_s_hs) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_s_data;
    end
  end

endmodule

// File: rtl/axi_region_remap.sv
// rtl/axi_region_remap.sv - AR/AW region remap with register slices and miss counters
// Optional runtime-writable region table: AXI_REMAP_RUNTIME_CFG_EN.
module axi_region_remap
  import axi_remap_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int META_W      = META_W_DEF,
  parameter int REGION_BITS = REGION_BITS_DEF,
  parameter int N_REGIONS   = 1,
  parameter logic [N_REGIONS*REGION_BITS-1:0] MATCH_TABLE = 4'd2,
  parameter logic [N_REGIONS*REGION_BITS-1:0] REMAP_TABLE = 4'd4,
  parameter logic [REGION_BITS-1:0]           DEFAULT_HI  = 4'd1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [META_W-1:0] s_ar_meta,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [META_W-1:0] m_ar_meta,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [META_W-1:0] s_aw_meta,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [META_W-1:0] m_aw_meta,
`ifdef AXI_REMAP_RUNTIME_CFG_EN
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_idx,
  input  logic [REGION_BITS-1:0] cfg_match,
  input  logic [REGION_BITS-1:0] cfg_remap,
  input  logic                   cfg_en,
`endif
  output logic [CNT_W-1:0]  miss_cnt_ar,
  output logic [CNT_W-1:0]  miss_cnt_aw
);

  localparam int DW = ADDR_W + META_W;
  localparam int LW = ADDR_W - REGION_BITS;

  logic [MAX_REGIONS*MAX_RB-1:0] w_match_tab;
  logic [MAX_REGIONS*MAX_RB-1:0] w_remap_tab;
  logic [MAX_REGIONS-1:0]        w_en;

`ifdef AXI_REMAP_RUNTIME_CFG_EN
  logic [REGION_BITS-1:0] r_match [N_REGIONS];
  logic [REGION_BITS-1:0] r_remap [N_REGIONS];
  logic [N_REGIONS-1:0]   r_en;

  // Table updates land at the clock edge, so a same-cycle handshake sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        r_match[i] <= MATCH_TABLE[i*REGION_BITS +: REGION_BITS];
        r_remap[i] <= REMAP_TABLE[i*REGION_BITS +: REGION_BITS];
        r_en[i]    <= 1'b1;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (cfg_idx == 3'(i)) begin
          r_match[i] <= cfg_match;
          r_remap[i] <= cfg_remap;
          r_en[i]    <= cfg_en;
        end
      end
    end
  end

  always_comb begin
    w_match_tab = '0;
    w_remap_tab = '0;
    w_en        = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      w_match_tab[i*MAX_RB +: MAX_RB] = MAX_RB'(r_match[i]);
      w_remap_tab[i*MAX_RB +: MAX_RB] = MAX_RB'(r_remap[i]);
      w_en[i]                         = r_en[i];
    end
  end
`else
  always_comb begin
    w_match_tab = '0;
    w_remap_tab = '0;
    w_en        = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      w_match_tab[i*MAX_RB +: MAX_RB] = MAX_RB'(MATCH_TABLE[i*REGION_BITS +: REGION_BITS]);
      w_remap_tab[i*MAX_RB +: MAX_RB] = MAX_RB'(REMAP_TABLE[i*REGION_BITS +: REGION_BITS]);
      w_en[i]                         = 1'b1;
    end
  end
`endif

  remap_res_t        w_ar_res;
  remap_res_t        w_aw_res;
  logic [ADDR_W-1:0] w_ar_addr;
  logic [ADDR_W-1:0] w_aw_addr;

  assign w_ar_res = remap_hi(MAX_RB'(s_ar_addr[ADDR_W-1 -: REGION_BITS]),
                             w_match_tab, w_remap_tab, w_en, MAX_RB'(DEFAULT_HI));
  assign w_aw_res = remap_hi(MAX_RB'(s_aw_addr[ADDR_W-1 -: REGION_BITS]),
                             w_match_tab, w_remap_tab, w_en, MAX_RB'(DEFAULT_HI));

  // Only the low REGION_BITS of the padded lookup result survive the truncation.
  assign w_ar_addr = ADDR_W'({w_ar_res.hi, s_ar_addr[LW-1:0]});
  assign w_aw_addr = ADDR_W'({w_aw_res.hi, s_aw_addr[LW-1:0]});

  axi_skid_slice #(.WIDTH(DW)) u_ar_slice (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_s_valid (s_ar_valid),
    .o_s_ready (s_ar_ready),
    .i_s_data  ({w_ar_addr, s_ar_meta}),
    .o_m_valid (m_ar_valid),
    .i_m_ready (m_ar_ready),
    .o_m_data  ({m_ar_addr, m_ar_meta})
  );

  axi_skid_slice #(.WIDTH(DW)) u_aw_slice (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_s_valid (s_aw_valid),
    .o_s_ready (s_aw_ready),
    .i_s_data  ({w_aw_addr, s_aw_meta}),
    .o_m_valid (m_aw_valid),
    .i_m_ready (m_aw_ready),
    .o_m_data  ({m_aw_addr, m_aw_meta})
  );

  logic [CNT_W-1:0] r_miss_ar;
  logic [CNT_W-1:0] r_miss_aw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss_ar <= '0;
      r_miss_aw <= '0;
    end else begin
      if (s_ar_valid && s_ar_ready && !w_ar_res.hit && (r_miss_ar != '1)) begin
        r_miss_ar <= r_miss_ar + CNT_W'(1);
      end
      if (s_aw_valid && s_aw_ready && !w_aw_res.hit && (r_miss_aw != '1)) begin
        r_miss_aw <= r_miss_aw + CNT_W'(1);
      end
    end
  end

  assign miss_cnt_ar = r_miss_ar;
  assign miss_cnt_aw = r_miss_aw;

endmodule

// File: tb/tb_axi_region_remap.sv
// tb/tb_axi_region_remap.sv - directed and randomized bench for axi_region_remap
module tb_axi_region_remap;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        ar_sv, ar_sr, ar_mv, ar_mr;
  logic [31:0] ar_sa, ar_ma;
  logic [30:0] ar_sm, ar_mm;
  logic        aw_sv, aw_sr, aw_mv, aw_mr;
  logic [31:0] aw_sa, aw_ma;
  logic [30:0] aw_sm, aw_mm;
  logic [15:0] miss_ar, miss_aw;

  logic        d2_sv, d2_sr, d2_mv, d2_mr;
  logic [31:0] d2_sa, d2_ma;
  logic [30:0] d2_sm, d2_mm;
  logic        d2_aw_sr, d2_aw_mv;
  logic [31:0] d2_aw_ma;
  logic [30:0] d2_aw_mm;
  logic [1:0]  d2_miss, d2_miss_aw;

`ifdef AXI_REMAP_RUNTIME_CFG_EN
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [3:0]  cfg_match, cfg_remap;
  logic        cfg_en;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: region table, per-channel FIFOs of expected beats, miss counts
  int          tm [8];
  int          tr [8];
  bit          te [8];
  int          tn = 1;
  int          tdef = 1;
  logic [62:0] q_ar[$];
  logic [62:0] q_aw[$];
  int          miss_m [2];

  axi_region_remap u_dut (
    .clk(clk), .reset(reset),
    .s_ar_valid(ar_sv), .s_ar_ready(ar_sr), .s_ar_addr(ar_sa), .s_ar_meta(ar_sm),
    .m_ar_valid(ar_mv), .m_ar_ready(ar_mr), .m_ar_addr(ar_ma), .m_ar_meta(ar_mm),
    .s_aw_valid(aw_sv), .s_aw_ready(aw_sr), .s_aw_addr(aw_sa), .s_aw_meta(aw_sm),
    .m_aw_valid(aw_mv), .m_aw_ready(aw_mr), .m_aw_addr(aw_ma), .m_aw_meta(aw_mm),
`ifdef AXI_REMAP_RUNTIME_CFG_EN
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_match(cfg_match), .cfg_remap(cfg_remap), .cfg_en(cfg_en),
`endif
    .miss_cnt_ar(miss_ar), .miss_cnt_aw(miss_aw)
  );

  axi_region_remap #(
    .N_REGIONS(2), .MATCH_TABLE(8'h22), .REMAP_TABLE(8'h64), .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .s_ar_valid(d2_sv), .s_ar_ready(d2_sr), .s_ar_addr(d2_sa), .s_ar_meta(d2_sm),
    .m_ar_valid(d2_mv), .m_ar_ready(d2_mr), .m_ar_addr(d2_ma), .m_ar_meta(d2_mm),
    .s_aw_valid(1'b0), .s_aw_ready(d2_aw_sr), .s_aw_addr(32'h0), .s_aw_meta(31'h0),
    .m_aw_valid(d2_aw_mv), .m_aw_ready(1'b1), .m_aw_addr(d2_aw_ma), .m_aw_meta(d2_aw_mm),
`ifdef AXI_REMAP_RUNTIME_CFG_EN
    .cfg_we(1'b0), .cfg_idx(3'd0), .cfg_match(4'd0), .cfg_remap(4'd0), .cfg_en(1'b0),
`endif
    .miss_cnt_ar(d2_miss), .miss_cnt_aw(d2_miss_aw)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_map(input logic [31:0] a, output bit miss);
    int hi = int'(a >> 28);
    miss = 1'b0;
    for (int i = 0; i < tn; i++) begin
      if (te[i] && tm[i] == hi) return (32'(tr[i]) << 28) | (a & 32'h0FFF_FFFF);
    end
    miss = 1'b1;
    return (32'(tdef) << 28) | (a & 32'h0FFF_FFFF);
  endfunction

  task automatic chan(input int ch);
    logic [62:0] q[$];
    logic        sv, mr, sr, mv;
    logic [31:0] sa, ma, ea;
    logic [30:0] sm, mm;
    logic [15:0] mc;
    bit          m;
    int          occ;
    string       p;
    if (ch == 0) begin
      q = q_ar; sv = ar_sv; mr = ar_mr; sr = ar_sr; mv = ar_mv;
      sa = ar_sa; ma = ar_ma; sm = ar_sm; mm = ar_mm; mc = miss_ar; p = "ar";
    end else begin
      q = q_aw; sv = aw_sv; mr = aw_mr; sr = aw_sr; mv = aw_mv;
      sa = aw_sa; ma = aw_ma; sm = aw_sm; mm = aw_mm; mc = miss_aw; p = "aw";
    end
    occ = q.size();
    chk({p, "_s_ready"}, 64'(sr), 64'(occ < 2));
    chk({p, "_m_valid"}, 64'(mv), 64'(occ > 0));
    chk({p, "_miss_cnt"}, 64'(mc), 64'(miss_m[ch]));
    if (occ > 0) begin
      chk({p, "_m_addr"}, 64'(ma), 64'(q[0][62:31]));
      chk({p, "_m_meta"}, 64'(mm), 64'(q[0][30:0]));
    end
    if (mr === 1'b1 && occ > 0) void'(q.pop_front());
    if (sv === 1'b1 && occ < 2) begin
      ea = ref_map(sa, m);
      q.push_back({ea, sm});
      if (m && miss_m[ch] < 65535) miss_m[ch]++;
    end
    if (ch == 0) q_ar = q; else q_aw = q;
  endtask

  // One clock: check both channels mid-cycle, advance the model, step past the edge.
  task automatic tick();
    @(negedge clk);
    chan(0);
    chan(1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[31:28] = ($urandom_range(0, 2) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    logic [30:0] m1, m2;
    int sent;
    bit acc;
    tm[0] = 2; tr[0] = 4; te[0] = 1'b1;
    ar_sv = 0; ar_mr = 0; ar_sa = 0; ar_sm = 0;
    aw_sv = 0; aw_mr = 0; aw_sa = 0; aw_sm = 0;
    d2_sv = 0; d2_mr = 1; d2_sa = 0; d2_sm = 0;
`ifdef AXI_REMAP_RUNTIME_CFG_EN
    cfg_we = 0; cfg_idx = 0; cfg_match = 0; cfg_remap = 0; cfg_en = 0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ar_m_valid", 64'(ar_mv), 64'd0);
    chk("rst_aw_m_valid", 64'(aw_mv), 64'd0);
    chk("rst_ar_s_ready", 64'(ar_sr), 64'd0);
    chk("rst_aw_s_ready", 64'(aw_sr), 64'd0);
    chk("rst_miss_ar", 64'(miss_ar), 64'd0);
    chk("rst_miss_aw", 64'(miss_aw), 64'd0);
    reset = 0;
    #1;
    chk("post_rst_ar_s_ready", 64'(ar_sr), 64'd1);
    tick();

    // Region hit, one-cycle latency
    m1 = 31'($urandom);
    ar_sv = 1; ar_sa = 32'h2123_4560; ar_sm = m1;
    tick();
    ar_sv = 0;
    chk("hit_m_valid", 64'(ar_mv), 64'd1);
    chk("hit_m_addr", 64'(ar_ma), 64'h4123_4560);
    chk("hit_m_meta", 64'(ar_mm), 64'(m1));
    chk("hit_miss_cnt", 64'(miss_ar), 64'd0);
    ar_mr = 1;
    tick();

    // Misses go to the default region
    m1 = 31'($urandom); m2 = 31'($urandom);
    ar_sv = 1; ar_sa = 32'h0000_1000; ar_sm = m1;
    tick();
    chk("miss0_m_addr", 64'(ar_ma), 64'h1000_1000);
    chk("miss0_m_meta", 64'(ar_mm), 64'(m1));
    ar_sa = 32'h7FFF_FFF0; ar_sm = m2;
    tick();
    ar_sv = 0;
    chk("miss1_m_addr", 64'(ar_ma), 64'h1FFF_FFF0);
    chk("miss1_m_meta", 64'(ar_mm), 64'(m2));
    chk("miss_cnt_two", 64'(miss_ar), 64'd2);
    tick();

    // AW back-to-back stream against a 1,0,0 ready pattern
    sent = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      aw_sv = (sent < 8);
      aw_sa = (32'(sent) << 28) | 32'(sent * 16 + 8);
      aw_sm = 31'(sent + 100);
      aw_mr = (cyc % 3 == 0);
      acc = aw_sv && (q_aw.size() < 2);
      tick();
      if (acc) sent++;
    end
    aw_sv = 0;
    chk("aw_stream_sent", 64'(sent), 64'd8);
    chk("aw_stream_drained", 64'(aw_mv), 64'd0);

    // Two-entry table, lowest index wins; narrow counter saturates
    d2_sv = 1; d2_sa = 32'h2ABC_0000; d2_sm = 31'h1234;
    @(posedge clk); #1;
    chk("d2_prio_addr", 64'(d2_ma), 64'h4ABC_0000);
    chk("d2_prio_miss", 64'(d2_miss), 64'd0);
    for (int k = 0; k < 5; k++) begin
      d2_sa = 32'h3000_0000 + 32'(k);
      @(posedge clk); #1;
      chk("d2_miss_addr", 64'(d2_ma), 64'(32'h1000_0000 + 32'(k)));
      chk("d2_miss_sat", 64'(d2_miss), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    d2_sv = 0;

    // Reset with two beats buffered
    ar_mr = 0; ar_sv = 1;
    ar_sa = 32'h5000_0001; ar_sm = 31'h11;
    tick();
    ar_sa = 32'h2000_0002; ar_sm = 31'h22;
    tick();
    ar_sv = 0;
    tick();
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_ar_m_valid", 64'(ar_mv), 64'd0);
    chk("midrst_ar_s_ready", 64'(ar_sr), 64'd0);
    chk("midrst_miss_ar", 64'(miss_ar), 64'd0);
    chk("midrst_miss_aw", 64'(miss_aw), 64'd0);
    q_ar.delete(); q_aw.delete(); miss_m[0] = 0; miss_m[1] = 0;
    reset = 0;
    #1;
    chk("midrst_release_ready", 64'(ar_sr), 64'd1);
    tick();

`ifdef AXI_REMAP_RUNTIME_CFG_EN
    ar_mr = 1;
    ar_sv = 1; ar_sa = 32'h2000_0000; ar_sm = 31'h5;
    cfg_we = 1; cfg_idx = 0; cfg_match = 2; cfg_remap = 8; cfg_en = 1;
    tick();
    tm[0] = 2; tr[0] = 8; te[0] = 1'b1;
    cfg_we = 0;
    chk("cfg_same_cycle_addr", 64'(ar_ma), 64'h4000_0000);
    tick();
    chk("cfg_next_addr", 64'(ar_ma), 64'h8000_0000);
    ar_sv = 0;
    cfg_we = 1; cfg_idx = 5; cfg_match = 2; cfg_remap = 3; cfg_en = 1;
    tick();
    cfg_idx = 0; cfg_en = 0; cfg_remap = 8;
    tick();
    te[0] = 1'b0;
    cfg_we = 0;
    ar_sv = 1; ar_sa = 32'h2000_0000;
    tick();
    ar_sv = 0;
    chk("cfg_disabled_addr", 64'(ar_ma), 64'h1000_0000);
    chk("cfg_disabled_miss", 64'(miss_ar), 64'd1);
    tick();
`endif

    // Randomized traffic on both channels
    for (int cyc = 0; cyc < 400; cyc++) begin
      ar_sv = ($urandom_range(0, 3) != 0);
      ar_sa = rand_addr();
      ar_sm = 31'($urandom);
      ar_mr = ($urandom_range(0, 9) < 7);
      aw_sv = ($urandom_range(0, 3) != 0);
      aw_sa = rand_addr();
      aw_sm = 31'($urandom);
      aw_mr = ($urandom_range(0, 9) < 6);
      tick();
    end
    ar_sv = 0; aw_sv = 0; ar_mr = 1; aw_mr = 1;
    repeat (3) tick();
    chk("final_ar_drained", 64'(ar_mv), 64'd0);
    chk("final_aw_drained", 64'(aw_mv), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_region_remap.md
Name: axi_region_remap

Overview:
- Parametrised address-remap stage between the Rocket Top memory master and the PS slave AXI port.
- Generalises the fixed "region 2 -> 4, else -> 1" map into an N-entry region table with a default region.
- Adds a full-throughput register slice (skid buffer) on both the AR and AW channels, plus per-channel saturating miss counters.
- W, R and B channels bypass this block.

Parameters:
- ADDR_W, 32, AXI address width.
- META_W, 31, packed AR/AW sideband width: id6, len8, size3, burst2, lock1, cache4, prot3, qos4 (MSB to LSB).
- REGION_BITS, 4, number of upper address bits compared and replaced.
- N_REGIONS, 1, number of table entries (1..8).
- MATCH_TABLE, {4'd2}, packed N_REGIONS x REGION_BITS; entry i matches when the upper address bits equal this value.
- REMAP_TABLE, {4'd4}, packed N_REGIONS x REGION_BITS; replacement upper bits for entry i.
- DEFAULT_HI, 4'd1, replacement upper bits when no entry matches.
- CNT_W, 16, miss counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- s_ar_valid / s_ar_ready  in / out  1 / 1  upstream AR handshake
- s_ar_addr  in  ADDR_W  upstream AR address
- s_ar_meta  in  META_W  upstream AR sideband
- m_ar_valid / m_ar_ready  out / in  1 / 1  downstream AR handshake
- m_ar_addr  out  ADDR_W  remapped AR address
- m_ar_meta  out  META_W  AR sideband, passed through unchanged
- s_aw_*, m_aw_*  same set of ports as AR, for the write-address channel
- miss_cnt_ar, miss_cnt_aw  out  CNT_W  saturating unmapped-request counters

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: m_*_valid=0; s_*_ready=0 while reset is high and 1 in the first cycle after reset deasserts; miss_cnt_*=0; skid entries invalid.
- Remap (combinational, on s_*_addr before capture):
  - hi = addr[ADDR_W-1 -: REGION_BITS].
  - The lowest index i with MATCH_TABLE[i]==hi wins; hi is replaced by REMAP_TABLE[i].
  - If no entry matches, hi is replaced by DEFAULT_HI and the request counts as a miss.
  - addr[ADDR_W-REGION_BITS-1:0] passes through untouched.
  - Meta is never altered.
- Register slice, per channel, independent: two entries (main, skid).
  - Latency: accepted on cycle n, m_valid=1 on cycle n+1.
  - Throughput: 1 beat/cycle while m_ready=1.
  - s_ready = !skid_valid (registered).
  - Upstream handshake while main is valid and m_ready=0: beat goes to skid, s_ready drops the next cycle.
  - On a downstream handshake, skid moves into main.
  - Simultaneous s and m handshakes: main is replaced, skid stays empty.
  - Ordering is strictly FIFO.
  - m_valid, once high, stays high with stable addr/meta until m_ready (AXI rule).
- Miss counters:
  - Increment on an upstream handshake whose address missed.
  - Saturate at all-ones; no wrap.
  - AR and AW are counted independently.
- Reset mid-operation: buffered beats are dropped; counters clear. Upstream must not hold an outstanding valid across reset.

Optional Feature:
- Macro: AXI_REMAP_RUNTIME_CFG_EN.
- When defined, adds ports:
  - cfg_we  in  1
  - cfg_idx  in  3
  - cfg_match  in  REGION_BITS
  - cfg_remap  in  REGION_BITS
  - cfg_en  in  1
- Table and per-entry enable registers are initialised from the parameters on reset (all enables 1).
- cfg_we writes entry cfg_idx; writes to cfg_idx>=N_REGIONS are ignored.
- A write takes effect for handshakes from the next cycle. A handshake in the same cycle as cfg_we uses the old table. Already-buffered beats keep their old mapping.
- Disabled entries never match.
- When undefined: the table is constant from the parameters, no cfg ports exist, and table logic reduces to constants.

Decomposition:
- Package axi_remap_pkg:
  - REGION_BITS default.
  - META field offsets and widths.
  - remap_hi() function returning {hit, new_hi}.
- Sub-module axi_skid_slice (WIDTH = ADDR_W+META_W), instantiated once for AR and once for AW.
- Remap and counter logic live in the top module.

Test Plan:
- Default params, AR addr 0x2123_4560 -> m_ar_addr 0x4123_4560 one cycle later; miss_cnt_ar stays 0.
- AR addr 0x0000_1000 and 0x7FFF_FFF0 -> 0x1000_1000 and 0x1FFF_FFF0; miss_cnt_ar=2; meta bit-identical.
- Back-to-back AW stream of 8 beats, m_aw_ready toggling 1,0,0,1,... -> all 8 delivered in order with no loss or duplication; s_aw_ready drops exactly one cycle after skid fills.
- N_REGIONS=2, MATCH={2,2}, REMAP={4,6} -> 0x2xxx maps to 0x4xxx (lowest-index priority); CNT_W=2 with 5 misses -> counter holds 3.
- Assert reset with 2 beats buffered -> m_ar_valid=0 the next cycle, counters 0, s_ar_ready=0 during reset and 1 after release.
- RUNTIME_CFG_EN: write idx0 match=2 remap=8 in the same cycle as an AR at 0x2000_0000 -> that beat goes to 0x4000_0000, the next 0x2000_0000 goes to 0x8000_0000; cfg_en=0 on idx0 -> 0x1000_0000 and a miss is counted.
